wb_arbiter_2m: RTL and testbench

Two-master, one-slave Wishbone classic arbiter for the shared external memory bus (SRAM/PSRAM holding dictionary and bitvector tables). Master 0 is the host-side bridge, which loads dictionary and vector tables. Master 1 is the edit-distance search engine's read port. The arbiter adds round-robin grant with bus lock for the whole cyc duration, and a per-access watchdog that converts a hung slave into an err termination.

---
 rtl/wb_arbiter_pkg.sv | 6 +
 rtl/wb_watchdog.sv | 28 ++
 rtl/wb_arbiter_2m.sv | 94 +++++++++
 tb/tb_wb_arbiter_2m.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared FSM state encoding and grant indices for the two-master Wishbone arbiter
package wb_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;
endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog: per-access stall counter that raises a one-cycle err pulse when the slave never answers
// Ports: clk_i/rst_i clock and async reset; en_i counts a stalled strobe cycle; clr_i restarts the count;
//        term_i slave termination present this cycle; err_o single-cycle timeout pulse.
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic term_i,
    output logic err_o
);
    localparam bit                     ENABLED = TIMEOUT_CYCLES != 0;
    localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
    logic [TIMEOUT_WIDTH-1:0] cnt;
    // A slave termination in the timeout cycle wins over the local err.
    assign err_o = ENABLED && en_i && !term_i && cnt == LIMIT;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (clr_i || term_i || !en_i || err_o || !ENABLED)
            cnt <= '0;
        else
            cnt <= cnt + TIMEOUT_WIDTH'(1);
    end
endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: two-master Wishbone classic arbiter with round-robin grant, cyc-long bus lock and watchdog
// Ports: clk_i/rst_i clock and async reset; m0_*/m1_* master buses (cyc/stb/we/adr/dat in, ack/err/rty/dat out);
//        s_* slave bus (cyc/stb/we/adr/dat out, ack/err/rty/dat in).
module wb_arbiter_2m
    import wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = 24,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_rty_o,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_rty_o,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    input  logic [DATA_WIDTH-1:0] s_dat_i
);
    state_t state, state_nx;
    logic   last_grant, last_nx;
    logic   g0, g1, wd_en, wd_clr, wd_err, term;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= GRANT_M1;
        end else begin
            state      <= state_nx;
            last_grant <= last_nx;
        end
    end
    // The owner keeps the bus for its whole cyc; a waiting master takes over with no idle cycle.
    always_comb begin
        last_nx  = (state == GRANT0 && !m0_cyc_i) ? GRANT_M0 :
                   (state == GRANT1 && !m1_cyc_i) ? GRANT_M1 : last_grant;
        state_nx = state == GRANT0 ? (m0_cyc_i ? GRANT0 : m1_cyc_i ? GRANT1 : IDLE) :
                   state == GRANT1 ? (m1_cyc_i ? GRANT1 : m0_cyc_i ? GRANT0 : IDLE) :
                   (m0_cyc_i && m1_cyc_i) ? (last_grant == GRANT_M1 ? GRANT0 : GRANT1) :
                   m0_cyc_i ? GRANT0 : m1_cyc_i ? GRANT1 : IDLE;
    end
    always_comb begin
        g0       = state == GRANT0;
        g1       = state == GRANT1;
        s_cyc_o  = g0 ? m0_cyc_i : g1 & m1_cyc_i;
        s_stb_o  = g0 ? m0_stb_i : g1 & m1_stb_i;
        s_we_o   = g0 ? m0_we_i  : g1 & m1_we_i;
        s_adr_o  = g0 ? m0_adr_i : g1 ? m1_adr_i : '0;
        s_dat_o  = g0 ? m0_dat_i : g1 ? m1_dat_i : '0;
        m0_ack_o = g0 & s_ack_i;
        m0_err_o = g0 & (s_err_i | wd_err);
        m0_rty_o = g0 & s_rty_i;
        m1_ack_o = g1 & s_ack_i;
        m1_err_o = g1 & (s_err_i | wd_err);
        m1_rty_o = g1 & s_rty_i;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
    end
    assign term   = s_ack_i | s_err_i | s_rty_i;
    assign wd_en  = (state != IDLE) & s_stb_o;
    assign wd_clr = state_nx != state;
    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_wd (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (wd_en),
        .clr_i (wd_clr),
        .term_i(term),
        .err_o (wd_err)
    );
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: directed bench for the two-master arbiter, one DUT with a 4-cycle watchdog and one with it disabled
module tb_wb_arbiter_2m;
    localparam int AW = 24;
    localparam int DW = 8;
    localparam int T  = 4;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0, m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [AW-1:0] m0_adr_i = '0, m1_adr_i = '0;
    logic [DW-1:0] m0_dat_i = '0, m1_dat_i = '0, s_dat_i = '0;
    logic s_ack_i = 0, s_err_i = 0, s_rty_i = 0;
    logic m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o, s_cyc_o, s_stb_o, s_we_o;
    logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
    logic [AW-1:0] s_adr_o;
    logic z_m0_ack_o, z_m0_err_o, z_m0_rty_o, z_m1_ack_o, z_m1_err_o, z_m1_rty_o, z_s_cyc_o, z_s_stb_o, z_s_we_o;
    logic [DW-1:0] z_m0_dat_o, z_m1_dat_o, z_s_dat_o;
    logic [AW-1:0] z_s_adr_o;
    int n_cmp = 0;
    int n_bad = 0;
    int owner = -1;
    int last = 1;
    int run = 0;
    always #5 clk_i = ~clk_i;
    wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T), .TIMEOUT_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i)
    );
    wb_arbiter_2m #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0), .TIMEOUT_WIDTH(8)) dut_nowd (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_ack_o(z_m0_ack_o), .m0_err_o(z_m0_err_o), .m0_rty_o(z_m0_rty_o), .m0_dat_o(z_m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_ack_o(z_m1_ack_o), .m1_err_o(z_m1_err_o), .m1_rty_o(z_m1_rty_o), .m1_dat_o(z_m1_dat_o),
        .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o), .s_we_o(z_s_we_o), .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask
    task automatic sample();
        @(negedge clk_i);
    endtask
    function automatic bit cyc_of(input int m);
        return m == 0 ? m0_cyc_i : m1_cyc_i;
    endfunction
    function automatic bit stalled();
        return owner >= 0 && (owner == 0 ? m0_stb_i : m1_stb_i) && !(s_ack_i | s_err_i | s_rty_i);
    endfunction
    function automatic int run_cur();
        return stalled() ? run + 1 : 0;
    endfunction
    function automatic bit wd(input int lim);
        return lim != 0 && run_cur() == lim + 1;
    endfunction
    function automatic int nxt_owner();
        if (owner < 0)
            return (m0_cyc_i && m1_cyc_i) ? 1 - last : m0_cyc_i ? 0 : m1_cyc_i ? 1 : -1;
        if (cyc_of(owner))
            return owner;
        return cyc_of(1 - owner) ? 1 - owner : -1;
    endfunction
    function automatic logic [63:0] exp_vec(input int lim);
        logic g0, g1, e;
        g0 = owner == 0;
        g1 = owner == 1;
        e  = wd(lim);
        return 64'({g0 ? m0_cyc_i : g1 & m1_cyc_i, g0 ? m0_stb_i : g1 & m1_stb_i, g0 ? m0_we_i : g1 & m1_we_i,
                    g0 ? m0_adr_i : g1 ? m1_adr_i : 24'h0, g0 ? m0_dat_i : g1 ? m1_dat_i : 8'h0,
                    g0 & s_ack_i, g0 & (s_err_i | e), g0 & s_rty_i, g1 & s_ack_i, g1 & (s_err_i | e), g1 & s_rty_i,
                    s_dat_i, s_dat_i});
    endfunction
    // Model: owner of the bus, who released last, and the length of the current unanswered strobe run.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner <= -1;
            last  <= 1;
            run   <= 0;
        end else begin
            owner <= nxt_owner();
            last  <= (owner >= 0 && !cyc_of(owner)) ? owner : last;
            run   <= (nxt_owner() == owner && !wd(T)) ? run_cur() : 0;
        end
    end
    always @(negedge clk_i) begin
        chk("bus_wd4", 64'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, m0_ack_o, m0_err_o, m0_rty_o,
                            m1_ack_o, m1_err_o, m1_rty_o, m0_dat_o, m1_dat_o}), exp_vec(T));
        chk("bus_wd0", 64'({z_s_cyc_o, z_s_stb_o, z_s_we_o, z_s_adr_o, z_s_dat_o, z_m0_ack_o, z_m0_err_o, z_m0_rty_o,
                            z_m1_ack_o, z_m1_err_o, z_m1_rty_o, z_m0_dat_o, z_m1_dat_o}), exp_vec(0));
    end
    initial begin
        int e4, e0;
        sample();
        chk("rst_outputs", 64'({s_cyc_o, s_stb_o, s_adr_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'h0);
        step();
        rst_i = 0;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h800010;
        sample(); chk("t1_idle", 64'(s_cyc_o), 64'h0); step();
        sample(); chk("t1_cyc_rise", 64'({s_cyc_o, s_adr_o}), 64'({1'b1, 24'h800010})); step();
        sample(); step();
        s_ack_i = 1; s_dat_i = 8'h5A;
        sample(); chk("t1_ack", 64'({m1_ack_o, m1_dat_o, m0_ack_o}), 64'({1'b1, 8'h5A, 1'b0})); step();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        sample(); step();
        rst_i = 1; step(); rst_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 24'h000100; m0_dat_i = 8'h33;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 24'h800020;
        sample(); chk("t2_idle", 64'(s_cyc_o), 64'h0); step();
        s_ack_i = 1;
        sample(); chk("t2_grant0", 64'({s_adr_o, s_we_o, s_dat_o, m0_ack_o, m1_ack_o}), 64'({24'h000100, 1'b1, 8'h33, 1'b1, 1'b0})); step();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        sample(); chk("t2_release", 64'(s_cyc_o), 64'h0); step();
        sample(); chk("t2_handoff", 64'({s_cyc_o, s_adr_o}), 64'({1'b1, 24'h800020})); step();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int i = 0; i < 3; i++) begin
            s_ack_i = 1;
            sample(); chk("t3_ack", 64'({m1_ack_o, m0_ack_o, s_adr_o}), 64'({1'b1, 1'b0, 24'h800020})); step();
            s_ack_i = 0;
            sample(); chk("t3_lock", 64'(s_adr_o), 64'h800020); step();
        end
        m1_cyc_i = 0; m1_stb_i = 0;
        sample(); chk("t3_m1_drop", 64'(s_cyc_o), 64'h0); step();
        sample(); chk("t3_m0_granted", 64'({s_cyc_o, s_adr_o}), 64'({1'b1, 24'h000100})); step();
        m0_cyc_i = 0; m0_stb_i = 0;
        sample(); step();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        sample(); chk("t3_tie_idle", 64'(s_cyc_o), 64'h0); step();
        sample(); chk("t3_tie_m1", 64'({s_cyc_o, s_adr_o}), 64'({1'b1, 24'h800020})); step();
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m0_we_i = 0;
        sample(); step();
        m1_cyc_i = 1; m1_stb_i = 1;
        sample(); step();
        for (int k = 1; k <= 10; k++) begin
            sample(); chk("t4_wd_err", 64'(m1_err_o), 64'(k % 5 == 0)); step();
        end
        m1_cyc_i = 0; m1_stb_i = 0;
        sample(); step();
        m1_cyc_i = 1; m1_stb_i = 1;
        sample(); step();
        for (int k = 1; k <= 4; k++) begin
            sample(); chk("t5_wait", 64'(m1_err_o), 64'h0); step();
        end
        s_ack_i = 1;
        sample(); chk("t5_race", 64'({m1_ack_o, m1_err_o}), 64'({1'b1, 1'b0})); step();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        sample(); step();
        m0_cyc_i = 1; m0_stb_i = 1;
        sample(); step();
        e4 = 0; e0 = 0;
        repeat (1000) begin
            sample();
            e4 += int'(m0_err_o);
            e0 += int'(z_m0_err_o);
            step();
        end
        chk("t5_nowd_errs", 64'(e0), 64'h0);
        chk("t5_wd4_errs", 64'(e4), 64'd200);
        m0_cyc_i = 0; m0_stb_i = 0;
        sample(); step();
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 24'h000100;
        sample(); step();
        s_ack_i = 1;
        sample(); chk("t6_granted", 64'({s_cyc_o, m0_ack_o}), 64'({1'b1, 1'b1}));
        #2 rst_i = 1;
        #1 chk("t6_async", 64'({s_cyc_o, s_stb_o, s_adr_o, m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o}), 64'h0);
        @(posedge clk_i);
        #1;
        rst_i = 0; s_ack_i = 0; m1_cyc_i = 1; m1_stb_i = 1;
        sample(); chk("t6_idle", 64'(s_cyc_o), 64'h0); step();
        sample(); chk("t6_m0_wins", 64'({s_cyc_o, s_adr_o}), 64'({1'b1, 24'h000100})); step();
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        sample(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
